// File: rtl/wm_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : wm_cycle_controller
// Description : Washing-machine sequencing FSM with per-phase watchdog,
//               door-fault pause and cancel-to-drain path.
// Revision    : 1.0 - initial release
// ============================================================================
module wm_cycle_controller #(
    parameter int          LOCK_CYCLES   = 2,
    parameter logic [15:0] PHASE_TIMEOUT = 16'd1000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_Wash,
    input  logic       cancel,
    input  logic       door_Closed,
    input  logic       sig_Full,
    input  logic       sig_Temperature,
    input  logic       sig_Completed,
    output logic [2:0] state,
    output logic       door_Lock,
    output logic       water_Valve,
    output logic       heater_On,
    output logic       motor_On,
    output logic       drain_Valve,
    output logic       done,
    output logic       paused,
    output logic       aborted,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOCK  = 3'd1,
        S_FILL  = 3'd2,
        S_HEAT  = 3'd3,
        S_WASH  = 3'd4,
        S_RINSE = 3'd5,
        S_SPIN  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    localparam logic [15:0] c_LOCK_TARGET = 16'(LOCK_CYCLES);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_dwell;
    logic [15:0] r_lock_cnt;
    logic        r_prev_comp;
    logic        r_aborted;
    logic        r_error;
    logic        w_in_phase;
    logic        w_paused;
    logic        w_comp_rise;
    logic        w_lock_done;
    logic        w_set_abort;
    logic        w_set_error;

    assign w_in_phase  = r_state inside {S_FILL, S_HEAT, S_WASH, S_RINSE, S_SPIN};
    assign w_paused    = w_in_phase && !door_Closed;
    assign w_comp_rise = sig_Completed && !r_prev_comp;
    assign w_lock_done = (r_lock_cnt + 16'd1) >= c_LOCK_TARGET;

    // Priority inside a phase: pause, then watchdog, then cancel, then advance.
    always_comb begin
        w_next      = r_state;
        w_set_abort = 1'b0;
        w_set_error = 1'b0;
        case (r_state)
            S_IDLE: if (start_Wash && door_Closed) w_next = S_LOCK;
            S_LOCK: begin
                if (!door_Closed || cancel) w_next = S_IDLE;
                else if (w_lock_done)       w_next = S_FILL;
            end
            S_DONE: if (!door_Closed) w_next = S_IDLE;
            default: begin
                if (w_paused) begin
                    w_next = r_state;
                end else if (r_dwell >= PHASE_TIMEOUT) begin
                    w_next      = S_DONE;
                    w_set_error = 1'b1;
                end else if (cancel && (r_state != S_SPIN)) begin
                    w_next      = S_SPIN;
                    w_set_abort = 1'b1;
                end else begin
                    case (r_state)
                        S_FILL:  if (sig_Full)        w_next = S_HEAT;
                        S_HEAT:  if (sig_Temperature) w_next = S_WASH;
                        S_WASH:  if (w_comp_rise)     w_next = S_RINSE;
                        S_RINSE: if (w_comp_rise)     w_next = S_SPIN;
                        S_SPIN:  if (w_comp_rise)     w_next = S_DONE;
                        default: w_next = r_state;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_dwell     <= 16'd0;
            r_lock_cnt  <= 16'd0;
            r_prev_comp <= 1'b1;
            r_aborted   <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_prev_comp <= sig_Completed;

            if (w_next != r_state)
                r_dwell <= 16'd0;
            else if (!w_paused && w_in_phase && (r_dwell != 16'hFFFF))
                r_dwell <= r_dwell + 16'd1;

            if (w_next != r_state)
                r_lock_cnt <= 16'd0;
            else if (r_state == S_LOCK)
                r_lock_cnt <= r_lock_cnt + 16'd1;

            if ((r_state == S_DONE) && (w_next == S_IDLE)) begin
                r_aborted <= 1'b0;
                r_error   <= 1'b0;
            end else begin
                if (w_set_abort) r_aborted <= 1'b1;
                if (w_set_error) r_error   <= 1'b1;
            end
        end
    end

    always_comb begin
        door_Lock   = 1'b0;
        water_Valve = 1'b0;
        heater_On   = 1'b0;
        motor_On    = 1'b0;
        drain_Valve = 1'b0;
        case (r_state)
            S_LOCK:  door_Lock = 1'b1;
            S_FILL:  begin door_Lock = 1'b1; water_Valve = 1'b1; end
            S_HEAT:  begin door_Lock = 1'b1; heater_On   = 1'b1; end
            S_WASH:  begin door_Lock = 1'b1; motor_On    = 1'b1; end
            S_RINSE: begin door_Lock = 1'b1; water_Valve = 1'b1; motor_On = 1'b1; end
            S_SPIN:  begin door_Lock = 1'b1; drain_Valve = 1'b1; motor_On = 1'b1; end
            default: door_Lock = 1'b0;
        endcase
        // An open door mid-cycle keeps the lock engaged but kills everything else.
        if (w_paused) begin
            water_Valve = 1'b0;
            heater_On   = 1'b0;
            motor_On    = 1'b0;
            drain_Valve = 1'b0;
        end
    end

    assign state   = r_state;
    assign done    = (r_state == S_DONE);
    assign paused  = w_paused;
    assign aborted = r_aborted;
    assign error   = r_error;

endmodule
`default_nettype wire

// File: tb/tb_wm_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_wm_cycle_controller
// Description : Directed stimulus for wm_cycle_controller with a cycle-level
//               reference model compared on every falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wm_cycle_controller;

    localparam int LOCK_CYCLES = 2;
    localparam int TIMEOUT     = 20;

    logic       clock           = 1'b0;
    logic       reset_n         = 1'b0;
    logic       start_Wash      = 1'b0;
    logic       cancel          = 1'b0;
    logic       door_Closed     = 1'b0;
    logic       sig_Full        = 1'b0;
    logic       sig_Temperature = 1'b0;
    logic       sig_Completed   = 1'b0;
    logic [2:0] state;
    logic       door_Lock, water_Valve, heater_On, motor_On, drain_Valve;
    logic       done, paused, aborted, error;

    int tests_run    = 0;
    int tests_failed = 0;
    bit chk_en       = 1'b0;

    // Reference model state (reset values)
    int m_state = 0;
    int m_dwell = 0;
    int m_lock  = 0;
    int m_nxt   = 0;
    bit m_prev  = 1'b1;
    bit m_ab    = 1'b0;
    bit m_err   = 1'b0;
    bit m_rise, m_pause, m_adv, m_active;

    // {door_Lock, water_Valve, heater_On, motor_On, drain_Valve} per state code
    logic [4:0] act_tbl [0:7] = '{5'b00000, 5'b10000, 5'b11000, 5'b10100,
                                  5'b10010, 5'b11010, 5'b10011, 5'b00000};
    logic [4:0] exp_act;
    bit         exp_paused;

    wm_cycle_controller #(
        .LOCK_CYCLES  (LOCK_CYCLES),
        .PHASE_TIMEOUT(16'(TIMEOUT))
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start_Wash     (start_Wash),
        .cancel         (cancel),
        .door_Closed    (door_Closed),
        .sig_Full       (sig_Full),
        .sig_Temperature(sig_Temperature),
        .sig_Completed  (sig_Completed),
        .state          (state),
        .door_Lock      (door_Lock),
        .water_Valve    (water_Valve),
        .heater_On      (heater_On),
        .motor_On       (motor_On),
        .drain_Valve    (drain_Valve),
        .done           (done),
        .paused         (paused),
        .aborted        (aborted),
        .error          (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Model: one machine cycle computed from the behavioural rules.
    task automatic model_step();
        m_active = (m_state >= 2) && (m_state <= 6);
        m_rise   = sig_Completed && !m_prev;
        m_pause  = m_active && !door_Closed;
        case (m_state)
            2:       m_adv = sig_Full;
            3:       m_adv = sig_Temperature;
            4, 5, 6: m_adv = m_rise;
            default: m_adv = 1'b0;
        endcase
        m_nxt = m_state;
        if (m_state == 0) begin
            if (start_Wash && door_Closed) m_nxt = 1;
        end else if (m_state == 1) begin
            if (!door_Closed || cancel) m_nxt = 0;
            else if (m_lock + 1 >= LOCK_CYCLES) m_nxt = 2;
        end else if (m_state == 7) begin
            if (!door_Closed) begin
                m_nxt = 0;
                m_ab  = 1'b0;
                m_err = 1'b0;
            end
        end else if (!m_pause) begin
            if (m_dwell >= TIMEOUT) begin
                m_nxt = 7;
                m_err = 1'b1;
            end else if (cancel && m_state != 6) begin
                m_nxt = 6;
                m_ab  = 1'b1;
            end else if (m_adv) begin
                m_nxt = m_state + 1;
            end
        end
        if (m_nxt != m_state) begin
            m_dwell = 0;
            m_lock  = 0;
        end else begin
            if (m_active && !m_pause && m_dwell < 65535) m_dwell++;
            if (m_state == 1) m_lock++;
        end
        m_state = m_nxt;
        m_prev  = sig_Completed;
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_state = 0; m_dwell = 0; m_lock = 0;
                m_prev  = 1'b1; m_ab = 1'b0; m_err = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                exp_paused = (m_state >= 2) && (m_state <= 6) && !door_Closed;
                exp_act    = exp_paused ? 5'b10000 : act_tbl[m_state];
                check("cmp_state",   state, m_state);
                check("cmp_actuators", {door_Lock, water_Valve, heater_On, motor_On, drain_Valve}, exp_act);
                check("cmp_done",    done, (m_state == 7));
                check("cmp_paused",  paused, exp_paused);
                check("cmp_aborted", aborted, m_ab);
                check("cmp_error",   error, m_err);
            end
        end
    end

    task automatic run_to_wash();
        door_Closed = 1'b1;
        start_Wash  = 1'b1;
        step(1);
        start_Wash  = 1'b0;
        step(2);
        sig_Full    = 1'b1;
        step(1);
        sig_Full        = 1'b0;
        sig_Temperature = 1'b1;
        step(1);
        sig_Temperature = 1'b0;
    endtask

    initial begin
        #12;
        check("reset_state", state, 0);
        check("reset_outputs", {door_Lock, water_Valve, heater_On, motor_On, drain_Valve,
                                done, paused, aborted, error}, 0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        step(1);

        // Full cycle with the door closed
        door_Closed = 1'b1;
        start_Wash  = 1'b1;
        step(1);  check("full_lock1", state, 1);
        start_Wash  = 1'b0;
        step(1);  check("full_lock2", state, 1);
        step(1);  check("full_fill", state, 2);
        step(2);
        sig_Full = 1'b1;
        step(1);  check("full_heat", state, 3);
        sig_Full = 1'b0;
        step(2);
        sig_Temperature = 1'b1;
        step(1);  check("full_wash", state, 4);
        sig_Temperature = 1'b0;
        step(3);
        sig_Completed = 1'b1;
        step(1);  check("full_rinse", state, 5);
        sig_Completed = 1'b0;
        step(3);
        sig_Completed = 1'b1;
        step(1);  check("full_spin", state, 6);
        sig_Completed = 1'b0;
        step(3);
        sig_Completed = 1'b1;
        step(1);  check("full_done_state", state, 7);
        check("full_done_flag", done, 1);
        sig_Completed = 1'b0;
        step(2);  check("full_done_hold", state, 7);
        door_Closed = 1'b0;
        step(1);  check("full_idle", state, 0);

        // Start with the door open is ignored
        start_Wash = 1'b1;
        step(3);
        check("open_start_state", state, 0);
        check("open_start_outputs", {door_Lock, water_Valve, heater_On, motor_On, drain_Valve,
                                     done, paused, aborted, error}, 0);
        start_Wash = 1'b0;

        // Held completion level: one advance, then the watchdog
        run_to_wash();
        sig_Completed = 1'b1;
        step(1);  check("held_rinse", state, 5);
        step(20); check("held_rinse_hold", state, 5);
        step(1);  check("held_wdog_state", state, 7);
        check("held_wdog_error", error, 1);
        door_Closed   = 1'b0;
        sig_Completed = 1'b0;
        step(1);  check("held_idle_error_clr", error, 0);

        // Cancel in HEAT
        door_Closed = 1'b1;
        start_Wash  = 1'b1;
        step(1);
        start_Wash  = 1'b0;
        step(2);
        sig_Full = 1'b1;
        step(1);
        sig_Full = 1'b0;
        step(1);
        cancel = 1'b1;
        step(1);  check("cancel_spin", state, 6);
        check("cancel_aborted", aborted, 1);
        cancel = 1'b0;
        step(2);
        sig_Completed = 1'b1;
        step(1);  check("cancel_done", state, 7);
        check("cancel_done_aborted", {done, aborted}, 2'b11);
        sig_Completed = 1'b0;
        door_Closed   = 1'b0;
        step(1);  check("cancel_idle_aborted_clr", aborted, 0);

        // Cancel and completion together in WASH; cancel ignored in SPIN
        run_to_wash();
        step(1);
        cancel        = 1'b1;
        sig_Completed = 1'b1;
        step(1);  check("cancel_wins_state", state, 6);
        sig_Completed = 1'b0;
        step(2);  check("cancel_in_spin_ignored", state, 6);
        cancel = 1'b0;
        sig_Completed = 1'b1;
        step(1);  check("cancel_wins_done", state, 7);
        sig_Completed = 1'b0;
        door_Closed   = 1'b0;
        step(1);

        // Door fault in WASH; a completion edge during the pause is lost
        run_to_wash();
        step(3);
        door_Closed = 1'b0;
        step(1);
        check("pause_state", state, 4);
        check("pause_outputs", {paused, door_Lock, motor_On}, 3'b110);
        sig_Completed = 1'b1;
        step(4);  check("pause_hold", state, 4);
        door_Closed = 1'b1;
        step(17); check("pause_resume_hold", state, 4);
        step(1);  check("pause_wdog_state", state, 7);
        check("pause_wdog_error", error, 1);
        door_Closed   = 1'b0;
        sig_Completed = 1'b0;
        step(1);

        // Asynchronous reset during RINSE
        run_to_wash();
        sig_Completed = 1'b1;
        step(1);
        sig_Completed = 1'b0;
        step(2);
        #2 reset_n = 1'b0;
        #1;
        check("areset_state", state, 0);
        check("areset_outputs", {door_Lock, water_Valve, heater_On, motor_On, drain_Valve,
                                 done, paused, aborted, error}, 0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        step(1);
        start_Wash = 1'b1;
        step(1);  check("restart_lock", state, 1);
        start_Wash = 1'b0;
        step(2);  check("restart_fill", state, 2);
        step(1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
